// File: rtl/demux1to4_32_buf_pkg.sv
// ---------------------------------------------------------------------------
// demux1to4_32_buf_pkg
// Shared constants and slot-state encoding for the buffered 1-to-4 word
// distributor (demux1to4_32_buf) and its per-port slot (demux_slot).
// ---------------------------------------------------------------------------
package demux1to4_32_buf_pkg;

    localparam int NUM_PORTS = 4;
    localparam int SEL_W     = 2;

    // One-entry slot: EMPTY means the port has nothing to offer its sink.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage : demux1to4_32_buf_pkg

// File: rtl/demux1to4_32_buf_demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
// One output port of the distributor: a one-entry data register with a
// valid bit (EMPTY/FULL state machine) and a wrapping delivery counter.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   i_wr        word accepted into this slot at this edge
//   i_data      word to store on i_wr
//   i_ready     sink consumes the held word this cycle
//   o_data      held word (keeps last value when EMPTY)
//   o_valid     slot is FULL
//   o_can_take  slot can accept a word this cycle (empty, or draining now)
//   o_cnt       number of words delivered to the sink, wraps silently
// ---------------------------------------------------------------------------
module demux_slot
    import demux1to4_32_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_can_take,
    output logic [CNT_W-1:0] o_cnt
);

    slot_state_e      r_state;
    slot_state_e      w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_deliver;

    assign w_deliver  = (r_state == SLOT_FULL) && i_ready;
    // A full slot being drained this cycle can be refilled at the same edge.
    assign o_can_take = (r_state == SLOT_EMPTY) || i_ready;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SLOT_EMPTY: if (i_wr) w_next_state = SLOT_FULL;
            SLOT_FULL:  if (w_deliver && !i_wr) w_next_state = SLOT_EMPTY;
            default:    w_next_state = SLOT_EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
            // NOTE: the data register is reset too, because the port data
            // is architecturally visible as zero right after reset.
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (i_wr) begin
                r_data <= i_data;
            end
            if (w_deliver) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = (r_state == SLOT_FULL);
    assign o_cnt   = r_cnt;

endmodule : demux_slot

// File: rtl/demux1to4_32_buf.sv
// ---------------------------------------------------------------------------
// demux1to4_32_buf
// Buffered 1-to-4 word distributor. One valid/ready input carrying a word
// and a 2-bit destination; four independently handshaked output ports, each
// backed by a one-entry slot, so a stalled sink never blocks the others.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_data/in_sel     word and destination port index
//   in_valid/in_ready  input handshake; in_ready reflects slot in_sel only
//   o0..o3             registered port data
//   o_valid[k]         port k holds a word
//   o_ready[k]         sink k consumes the word this cycle
//   cnt0..cnt3         per-port delivery counters (wrapping)
// ---------------------------------------------------------------------------
module demux1to4_32_buf
    import demux1to4_32_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     o0,
    output logic [WIDTH-1:0]     o1,
    output logic [WIDTH-1:0]     o2,
    output logic [WIDTH-1:0]     o3,
    output logic [NUM_PORTS-1:0] o_valid,
    input  logic [NUM_PORTS-1:0] o_ready,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1,
    output logic [CNT_W-1:0]     cnt2,
    output logic [CNT_W-1:0]     cnt3
);

    logic [NUM_PORTS-1:0] w_can_take;
    logic [NUM_PORTS-1:0] w_wr;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_data [NUM_PORTS];
    logic [CNT_W-1:0]     w_cnt  [NUM_PORTS];

    // Ready-to-ready path is combinational: a draining slot accepts at once.
    assign in_ready = w_can_take[in_sel];
    assign w_accept = in_valid && in_ready;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slot
        assign w_wr[k] = w_accept && (in_sel == SEL_W'(k));

        demux_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .i_wr       (w_wr[k]),
            .i_data     (in_data),
            .i_ready    (o_ready[k]),
            .o_data     (w_data[k]),
            .o_valid    (o_valid[k]),
            .o_can_take (w_can_take[k]),
            .o_cnt      (w_cnt[k])
        );
    end

    assign o0   = w_data[0];
    assign o1   = w_data[1];
    assign o2   = w_data[2];
    assign o3   = w_data[3];
    assign cnt0 = w_cnt[0];
    assign cnt1 = w_cnt[1];
    assign cnt2 = w_cnt[2];
    assign cnt3 = w_cnt[3];

endmodule : demux1to4_32_buf

// File: tb/tb_demux1to4_32_buf.sv
// ---------------------------------------------------------------------------
// tb_demux1to4_32_buf
// Self-checking bench for demux1to4_32_buf: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model in
// which each port is a FIFO of capacity one.
// ---------------------------------------------------------------------------
module tb_demux1to4_32_buf;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] o0, o1, o2, o3;
    logic [3:0]       o_valid;
    logic [3:0]       o_ready;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each port is a queue holding at most one word.
    logic [WIDTH-1:0] m_q    [4][$];
    logic [WIDTH-1:0] m_last [4];
    logic [CNT_W-1:0] m_cnt  [4];

    demux1to4_32_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .o0       (o0),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .cnt3     (cnt3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready(input logic [1:0] sel);
        return (m_q[sel].size() == 0) || o_ready[sel];
    endfunction

    // Apply the model's view of one clock edge using the current inputs.
    task automatic model_edge();
        bit acc;
        acc = in_valid && m_ready(in_sel);
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_q[k].delete();
                m_last[k] = '0;
                m_cnt[k]  = '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_q[k].size() != 0 && o_ready[k]) begin
                    void'(m_q[k].pop_front());
                    m_cnt[k] = m_cnt[k] + 1'b1;
                end
            end
            if (acc) begin
                m_q[in_sel].push_back(in_data);
                m_last[in_sel] = in_data;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] exp_v;
        for (int k = 0; k < 4; k++) exp_v[k] = (m_q[k].size() != 0);
        check({tag, ".o_valid"}, 64'(o_valid), 64'(exp_v));
        check({tag, ".o0"}, 64'(o0), 64'(m_last[0]));
        check({tag, ".o1"}, 64'(o1), 64'(m_last[1]));
        check({tag, ".o2"}, 64'(o2), 64'(m_last[2]));
        check({tag, ".o3"}, 64'(o3), 64'(m_last[3]));
        check({tag, ".cnt0"}, 64'(cnt0), 64'(m_cnt[0]));
        check({tag, ".cnt1"}, 64'(cnt1), 64'(m_cnt[1]));
        check({tag, ".cnt2"}, 64'(cnt2), 64'(m_cnt[2]));
        check({tag, ".cnt3"}, 64'(cnt3), 64'(m_cnt[3]));
    endtask

    // One cycle: drive inputs, check in_ready, clock, check all outputs.
    task automatic cycle(input string tag, input logic r, input logic v,
                         input logic [1:0] s, input logic [WIDTH-1:0] d,
                         input logic [3:0] rdy);
        rst      = r;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        o_ready  = rdy;
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(m_ready(s)));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; o_ready = '0;
        for (int k = 0; k < 4; k++) begin m_last[k] = '0; m_cnt[k] = '0; end

        // Reset then idle; in_ready must be 1 for every select value.
        cycle("rst0", 1, 0, 0, 0, 4'b0000);
        cycle("rst1", 1, 0, 0, 0, 4'b0000);
        for (int s = 0; s < 4; s++) cycle("idle", 0, 0, 2'(s), 32'hFFFF_FFFF, 4'b0000);
        check("idle.o_valid", 64'(o_valid), 64'h0);

        // Single route to port 2, stalled for 5 cycles, then drained.
        cycle("route", 0, 1, 2, 32'hDEAD_BEEF, 4'b0000);
        check("route.o_valid", 64'(o_valid), 64'b0100);
        check("route.o2", 64'(o2), 64'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) cycle("stall", 0, 0, 2, 32'h1234_5678, 4'b0000);
        check("stall.o2", 64'(o2), 64'hDEAD_BEEF);
        cycle("drain", 0, 0, 0, 0, 4'b0100);
        check("drain.o_valid", 64'(o_valid), 64'h0);
        check("drain.cnt2", 64'(cnt2), 64'd1);

        // Backpressure isolation: port 1 full and stalled.
        cycle("fill1", 0, 1, 1, 32'h0000_0011, 4'b0000);
        cycle("blk1", 0, 1, 1, 32'hBAD0_BAD0, 4'b0000);
        check("blk1.in_ready", 64'(in_ready), 64'h0);
        check("blk1.o1", 64'(o1), 64'h11);
        cycle("iso3", 0, 1, 3, 32'h0000_0033, 4'b0000);
        check("iso3.o_valid", 64'(o_valid), 64'b1010);
        check("iso3.o3", 64'(o3), 64'h33);

        // Streaming replace into port 0 with its sink always ready.
        for (int i = 1; i <= 10; i++) begin
            cycle("stream", 0, 1, 0, 32'(i), 4'b0001);
            check("stream.o0", 64'(o0), 64'(i));
        end
        cycle("stream_end", 0, 0, 0, 0, 4'b0001);
        check("stream.cnt0", 64'(cnt0), 64'd10);

        // Counter wrap: 256 deliveries on port 3 after a fresh reset.
        cycle("rst2", 1, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 256; i++) begin
            cycle("wrap", 0, 1, 3, $urandom, 4'b1000);
            if (i == 255) check("wrap.cnt3_255", 64'(cnt3), 64'd255);
        end
        cycle("wrap_end", 0, 0, 0, 0, 4'b1000);
        check("wrap.cnt3", 64'(cnt3), 64'd0);
        check("wrap.cnt0", 64'(cnt0), 64'd0);

        // Reset mid-operation with all four slots full and stalled.
        for (int k = 0; k < 4; k++) cycle("fillall", 0, 1, 2'(k), $urandom | 32'h1, 4'b0000);
        check("fillall.o_valid", 64'(o_valid), 64'b1111);
        cycle("rst_mid", 1, 0, 0, 0, 4'b1111);
        check("rst_mid.o_valid", 64'(o_valid), 64'h0);
        check("rst_mid.o0", 64'(o0), 64'h0);
        check("rst_mid.cnt3", 64'(cnt3), 64'h0);
        cycle("post_rst", 0, 0, 0, 0, 4'b1111);
        check("post_rst.cnt0", 64'(cnt0), 64'h0);

        // Randomized traffic against the model, with rare resets.
        for (int i = 0; i < 600; i++) begin
            cycle("rand", ($urandom_range(0, 99) == 0), 1'($urandom), 2'($urandom),
                  $urandom, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_demux1to4_32_buf
